divider_bcd_formatter: RTL and testbench
========================================

Name: divider_bcd_formatter

Overview:
- Sits directly downstream of the parameterised divider.
- Watches the divider's idle flag. When a division completes (idle rises), it captures quotient, remainder and not_valid.
- Converts quotient and remainder to packed BCD with a sequential shift-add-3 (double dabble) engine.
- Presents both results to the display/UART side with a one-cycle valid strobe.

Parameters:
- BITSIZE, 8, width of quotient/remainder; must match the divider.
- DIGITS, 3, BCD digits per result; must satisfy 10^DIGITS > 2^BITSIZE - 1.
- CNTSIZE, 4, bit counter width; must satisfy 2^CNTSIZE > BITSIZE.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  asynchronous, active-low reset (0 = reset)
- quotient  input  BITSIZE  divider quotient output
- remainder  input  BITSIZE  divider remainder output
- not_valid  input  1  divider divide-by-zero flag
- idle  input  1  divider idle flag
- quot_bcd  output  4*DIGITS  packed BCD quotient, digit 0 in bits [3:0]
- rem_bcd  output  4*DIGITS  packed BCD remainder
- div_error  output  1  last captured result was divide-by-zero
- bcd_valid  output  1  one-cycle strobe: quot_bcd/rem_bcd/div_error just updated
- busy  output  1  high in any state other than WAIT
- dropped  output  1  sticky: a completion arrived while busy and was lost

Behaviour:
- Reset (rst=0, async):
  - state=WAIT, idle_d=1.
  - quot_bcd=0, rem_bcd=0, div_error=0, bcd_valid=0, dropped=0, counter=0.
- Completion edge: idle=1 and idle_d=0 at a rising clock edge. idle_d is idle registered each cycle. idle_d resets to 1, so no false trigger after reset.
- States: WAIT, CONV_Q, CONV_R, DONE. busy = (state != WAIT).
- WAIT, on a completion edge at edge E:
  - Capture remainder into a holding register.
  - Capture not_valid into err_hold.
  - If not_valid=0: load quotient into the shift register, clear the BCD accumulator and counter, go to CONV_Q.
  - If not_valid=1: go to DONE with the error path selected (no conversion).
- Each CONV cycle:
  - Every accumulator digit >=5 gets +3 (combinational).
  - Then {accumulator, shift reg} shifts left by 1 and the counter increments.
- CONV_Q:
  - After BITSIZE shifts (edge E+BITSIZE), the accumulator moves to a quotient holding register.
  - The remainder is loaded into the shift register, accumulator and counter clear, go to CONV_R.
- CONV_R: after BITSIZE shifts (edge E+2*BITSIZE):
  - quot_bcd and rem_bcd are written, div_error=0, bcd_valid<=1, go to DONE.
- Error path: at edge E+1, quot_bcd and rem_bcd are set to all ones (digit code F = invalid marker), div_error=1, bcd_valid<=1.
- DONE: on the next edge, bcd_valid<=0 and state returns to WAIT. bcd_valid is therefore high for exactly one cycle.
- Latency:
  - Normal path: bcd_valid is high in the cycle after edge E+2*BITSIZE (E+16 at default).
  - Error path: bcd_valid is high in the cycle after edge E+1.
- Output hold: outputs are stable between strobes and change only on the bcd_valid-setting edge.
- Inputs are sampled only at the capture edge. Later changes on quotient/remainder/not_valid do not affect the conversion in flight.
- Completion edge while busy (including DONE): ignored, dropped<=1. dropped is cleared only by reset. Outputs of the conversion in flight are unaffected.
- Completion edge in the same cycle the FSM enters WAIT from DONE: not captured; it counts as busy and sets dropped.
- idle held high continuously: no further captures; only 0->1 transitions trigger.
- Reset mid-conversion: immediate abort. All outputs return to reset values and no bcd_valid is emitted.
- Arithmetic: the add-3 is per 4-bit digit, with no carry between digits. The accumulator is 4*DIGITS bits. Bits shifted out of the top are discarded; the parameter constraint guarantees none are lost.

Test Plan:
- Reset release with idle held at 1 for 50 cycles -> bcd_valid never asserts, busy=0, all outputs 0.
- idle 0->1 with quotient=28, remainder=4 (200/7), not_valid=0 -> exactly 16 edges later bcd_valid high one cycle, quot_bcd=0x028, rem_bcd=0x004, div_error=0.
- quotient=255, remainder=0 -> quot_bcd=0x255, rem_bcd=0x000. Then quotient=0, remainder=9 -> quot_bcd=0x000, rem_bcd=0x009, and previous values held until the new strobe.
- idle rise with not_valid=1 -> strobe in the cycle after edge E+1, quot_bcd=rem_bcd=0xFFF, div_error=1. A following valid 100/3 clears div_error and gives 0x033/0x001.
- Second idle rise at E+5 during conversion -> dropped=1, first result (28/4) still correct, no second strobe.
- rst=0 asserted at E+10 mid-conversion -> outputs immediately 0, busy=0. After release, no strobe occurs until a new idle rise.

Source files
------------

// File: rtl/divider_bcd_formatter.sv
// Captures divider completions on the rising edge of idle and converts quotient and
// remainder to packed BCD with a sequential double-dabble engine, then strobes bcd_valid.
module divider_bcd_formatter #(
    parameter int unsigned BITSIZE = 8,
    parameter int unsigned DIGITS  = 3,
    parameter int unsigned CNTSIZE = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [BITSIZE-1:0]    quotient,
    input  logic [BITSIZE-1:0]    remainder,
    input  logic                  not_valid,
    input  logic                  idle,
    output logic [4*DIGITS-1:0]   quot_bcd,
    output logic [4*DIGITS-1:0]   rem_bcd,
    output logic                  div_error,
    output logic                  bcd_valid,
    output logic                  busy,
    output logic                  dropped
);

    localparam int unsigned BCDW = 4 * DIGITS;

    typedef enum logic [1:0] {
        S_WAIT   = 2'd0,
        S_CONV_Q = 2'd1,
        S_CONV_R = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    state_t               r_state,     w_state;
    logic                 r_idle_d;
    logic [BITSIZE-1:0]   r_sr,        w_sr;
    logic [BCDW-1:0]      r_acc,       w_acc;
    logic [CNTSIZE-1:0]   r_cnt,       w_cnt;
    logic [BITSIZE-1:0]   r_rem_hold,  w_rem_hold;
    logic                 r_err_hold,  w_err_hold;
    logic [BCDW-1:0]      r_qhold,     w_qhold;
    logic [BCDW-1:0]      r_quot_bcd,  w_quot_bcd;
    logic [BCDW-1:0]      r_rem_bcd,   w_rem_bcd;
    logic                 r_div_error, w_div_error;
    logic                 r_bcd_valid, w_bcd_valid;
    logic                 r_busy,      w_busy;
    logic                 r_dropped,   w_dropped;

    logic                 w_comp;
    logic                 w_last;
    logic [BCDW-1:0]      w_adj;
    logic [BCDW-1:0]      w_acc_shift;
    logic [BITSIZE-1:0]   w_sr_shift;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_WAIT;
            r_idle_d    <= 1'b1;
            r_sr        <= '0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_rem_hold  <= '0;
            r_err_hold  <= 1'b0;
            r_qhold     <= '0;
            r_quot_bcd  <= '0;
            r_rem_bcd   <= '0;
            r_div_error <= 1'b0;
            r_bcd_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_dropped   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_idle_d    <= idle;
            r_sr        <= w_sr;
            r_acc       <= w_acc;
            r_cnt       <= w_cnt;
            r_rem_hold  <= w_rem_hold;
            r_err_hold  <= w_err_hold;
            r_qhold     <= w_qhold;
            r_quot_bcd  <= w_quot_bcd;
            r_rem_bcd   <= w_rem_bcd;
            r_div_error <= w_div_error;
            r_bcd_valid <= w_bcd_valid;
            r_busy      <= w_busy;
            r_dropped   <= w_dropped;
        end
    end

    // Next-state, double-dabble step and output updates
    always_comb begin
        w_state     = r_state;
        w_sr        = r_sr;
        w_acc       = r_acc;
        w_cnt       = r_cnt;
        w_rem_hold  = r_rem_hold;
        w_err_hold  = r_err_hold;
        w_qhold     = r_qhold;
        w_quot_bcd  = r_quot_bcd;
        w_rem_bcd   = r_rem_bcd;
        w_div_error = r_div_error;
        w_bcd_valid = 1'b0;
        w_adj       = r_acc;

        w_comp = idle & ~r_idle_d;
        w_last = (r_cnt == CNTSIZE'(BITSIZE - 1));

        // Add 3 to every digit >= 5, digit-local with no carry between digits
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (r_acc[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_acc[4*i +: 4] + 4'd3;
            end
        end
        w_acc_shift = {w_adj[BCDW-2:0], r_sr[BITSIZE-1]};
        w_sr_shift  = {r_sr[BITSIZE-2:0], 1'b0};

        w_dropped = r_dropped | (w_comp & (r_state != S_WAIT));

        case (r_state)
            S_WAIT: begin
                if (w_comp) begin
                    w_rem_hold = remainder;
                    w_err_hold = not_valid;
                    if (!not_valid) begin
                        w_sr    = quotient;
                        w_acc   = '0;
                        w_cnt   = '0;
                        w_state = S_CONV_Q;
                    end else begin
                        w_state = S_DONE;
                    end
                end
            end
            S_CONV_Q: begin
                w_acc = w_acc_shift;
                w_sr  = w_sr_shift;
                w_cnt = r_cnt + CNTSIZE'(1);
                if (w_last) begin
                    w_qhold = w_acc_shift;
                    w_sr    = r_rem_hold;
                    w_acc   = '0;
                    w_cnt   = '0;
                    w_state = S_CONV_R;
                end
            end
            S_CONV_R: begin
                w_acc = w_acc_shift;
                w_sr  = w_sr_shift;
                w_cnt = r_cnt + CNTSIZE'(1);
                if (w_last) begin
                    w_quot_bcd  = r_qhold;
                    w_rem_bcd   = w_acc_shift;
                    w_div_error = 1'b0;
                    w_bcd_valid = 1'b1;
                    w_state     = S_DONE;
                end
            end
            S_DONE: begin
                // A pending error is published here first, then DONE closes out the strobe
                if (r_err_hold) begin
                    w_quot_bcd  = '1;
                    w_rem_bcd   = '1;
                    w_div_error = 1'b1;
                    w_bcd_valid = 1'b1;
                    w_err_hold  = 1'b0;
                end else begin
                    w_state = S_WAIT;
                end
            end
            default: w_state = S_WAIT;
        endcase

        w_busy = (w_state != S_WAIT);
    end

    assign quot_bcd  = r_quot_bcd;
    assign rem_bcd   = r_rem_bcd;
    assign div_error = r_div_error;
    assign bcd_valid = r_bcd_valid;
    assign busy      = r_busy;
    assign dropped   = r_dropped;

endmodule

// File: tb/tb_divider_bcd_formatter.sv
// Scoreboard bench for divider_bcd_formatter: directed completions push expected BCD
// results and strobe cycle; a negedge monitor pops and checks on every bcd_valid.
module tb_divider_bcd_formatter;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        not_valid;
    logic        idle;
    logic [11:0] quot_bcd;
    logic [11:0] rem_bcd;
    logic        div_error;
    logic        bcd_valid;
    logic        busy;
    logic        dropped;

    typedef struct {
        logic [11:0] q;
        logic [11:0] r;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   e_cyc = 0;

    divider_bcd_formatter #(.BITSIZE(8), .DIGITS(3), .CNTSIZE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .quotient  (quotient),
        .remainder (remainder),
        .not_valid (not_valid),
        .idle      (idle),
        .quot_bcd  (quot_bcd),
        .rem_bcd   (rem_bcd),
        .div_error (div_error),
        .bcd_valid (bcd_valid),
        .busy      (busy),
        .dropped   (dropped)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every strobe must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (bcd_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_strobe: got q=%h r=%h err=%b expected no strobe (cyc %0d)",
                         quot_bcd, rem_bcd, div_error, cyc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quot_bcd", 32'(quot_bcd), 32'(e.q));
                chk("rem_bcd", 32'(rem_bcd), 32'(e.r));
                chk("div_error", 32'(div_error), 32'(e.err));
                chk("strobe_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    // Produce an idle 0->1 edge; returns at the negedge just before capture edge E
    task automatic complete(input logic [7:0] q, input logic [7:0] r, input logic nv);
        @(negedge clk);
        quotient  = q;
        remainder = r;
        not_valid = nv;
        idle      = 1'b0;
        @(negedge clk);
        idle  = 1'b1;
        e_cyc = cyc + 1;
    endtask

    task automatic expect_res(input logic [11:0] q, input logic [11:0] r, input logic err);
        exp_t e;
        e.q   = q;
        e.r   = r;
        e.err = err;
        e.cyc = e_cyc + (err ? 1 : 16);
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_until(input int c);
        int n;
        n = 0;
        while (cyc < c && n < 200) begin
            @(negedge clk);
            n++;
        end
    endtask

    initial begin
        rst       = 1'b0;
        idle      = 1'b1;
        quotient  = '0;
        remainder = '0;
        not_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_quot", 32'(quot_bcd), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_dropped", 32'(dropped), 32'h0);
        rst = 1'b1;

        // idle held high: no strobe, stays idle
        repeat (50) @(negedge clk);
        chk("idle_busy", 32'(busy), 32'h0);
        chk("idle_rem", 32'(rem_bcd), 32'h0);
        chk("idle_err", 32'(div_error), 32'h0);

        // 200/7
        complete(8'd28, 8'd4, 1'b0);
        expect_res(12'h028, 12'h004, 1'b0);
        @(negedge clk);
        chk("busy_in_conv", 32'(busy), 32'h1);
        wait_drain();
        chk("busy_after", 32'(busy), 32'h0);

        complete(8'd255, 8'd0, 1'b0);
        expect_res(12'h255, 12'h000, 1'b0);
        wait_drain();

        // inputs changed after capture must not leak in; previous result held
        complete(8'd0, 8'd9, 1'b0);
        expect_res(12'h000, 12'h009, 1'b0);
        @(negedge clk);
        quotient  = 8'hAA;
        remainder = 8'h55;
        not_valid = 1'b1;
        wait_until(e_cyc + 8);
        chk("hold_quot", 32'(quot_bcd), 32'h255);
        chk("hold_rem", 32'(rem_bcd), 32'h000);
        wait_drain();

        // divide by zero, then 100/3 clears the error
        complete(8'd0, 8'd0, 1'b1);
        expect_res(12'hFFF, 12'hFFF, 1'b1);
        wait_drain();
        complete(8'd33, 8'd1, 1'b0);
        expect_res(12'h033, 12'h001, 1'b0);
        wait_drain();

        // second idle rise at E+5 is dropped; first result intact
        complete(8'd28, 8'd4, 1'b0);
        expect_res(12'h028, 12'h004, 1'b0);
        wait_until(e_cyc + 3);
        quotient = 8'd99;
        idle     = 1'b0;
        @(negedge clk);
        idle = 1'b1;
        @(negedge clk);
        chk("dropped_set", 32'(dropped), 32'h1);
        wait_drain();
        repeat (20) @(negedge clk);
        chk("dropped_sticky", 32'(dropped), 32'h1);

        // reset mid-conversion aborts with no strobe
        complete(8'd123, 8'd45, 1'b0);
        wait_until(e_cyc + 10);
        rst = 1'b0;
        #1;
        chk("abort_quot", 32'(quot_bcd), 32'h0);
        chk("abort_busy", 32'(busy), 32'h0);
        chk("abort_dropped", 32'(dropped), 32'h0);
        chk("abort_valid", 32'(bcd_valid), 32'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (30) @(negedge clk);
        chk("post_abort_busy", 32'(busy), 32'h0);

        complete(8'd7, 8'd3, 1'b0);
        expect_res(12'h007, 12'h003, 1'b0);
        wait_drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
